jk_sync_counter: RTL and testbench

- Modulo-N synchronous up/down counter built from per-bit JK toggle stages.
- Each bit's j/k is derived from the lower bits' state, the same way the team's JK flip-flop cell is driven.
- Sits directly downstream of the JK flip-flop cell and consumes its toggle behaviour. It is the first multi-bit sequential stage in the flip-flop library.
- Used as a clock-domain event counter and divider feeding later timer/sequencer blocks.

---
 rtl/jk_sync_counter.sv | 123 ++++++++++++
 tb/tb_jk_sync_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: modulo-MODULUS synchronous up/down counter built from
// per-bit JK toggle stages. Bit i toggles when all lower bits are 1 (counting
// up) or all lower bits are 0 (counting down). Modulus wrap, synchronous
// clear and parallel load override the JK toggle path.
//
// Optional build macro: JK_COUNTER_GRAY_OUT_EN
//   defined   -> adds a registered gray-coded copy of the count on port gray
//   undefined -> gray port and its logic are absent
module jk_sync_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             carry,
   output logic             load_err
`ifdef JK_COUNTER_GRAY_OUT_EN
   ,
   output logic [WIDTH-1:0] gray
`endif
);

   // Parameter legality is checked once at elaboration.
   generate
      if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
         $error("jk_sync_counter: WIDTH=%0d outside 2..16", WIDTH);
      end
      if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
         $error("jk_sync_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] jk_j;
   logic [WIDTH-1:0] jk_k;
   logic [WIDTH-1:0] jk_next;
   logic [WIDTH-1:0] next_count;
   logic             at_max;
   logic             at_zero;
   logic             wrap;
   logic             load_bad;
   logic             carry_next;
   logic             load_err_next;

   assign at_max  = (count == MAX_CNT);
   assign at_zero = (count == '0);

   // Terminal count is valid regardless of en.
   assign tc = (up && at_max) || (!up && at_zero);

   // Per-bit JK drive: j = k = AND of lower bits (up) or of their inverses (down).
   always_comb begin
      jk_j    = '0;
      jk_j[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         jk_j[i] = jk_j[i-1] & (up ? count[i-1] : ~count[i-1]);
      end
      jk_k    = jk_j;
      jk_next = (jk_j & ~count) | (~jk_k & count);
   end

   assign wrap     = en && tc;
   assign load_bad = ({1'b0, load_val} >= MOD_EXT);

   // Next-state selection with priority clr > load > en > hold.
   always_comb begin
      next_count    = count;
      carry_next    = 1'b0;
      load_err_next = 1'b0;
      if (clr) begin
         next_count = '0;
      end else if (load) begin
         if (load_bad) begin
            next_count    = '0;
            load_err_next = 1'b1;
         end else begin
            next_count = load_val;
         end
      end else if (en) begin
         if (wrap) begin
            next_count = up ? '0 : MAX_CNT;
            carry_next = 1'b1;
         end else begin
            next_count = jk_next;
         end
      end
   end

   // Count and status pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count    <= '0;
         carry    <= 1'b0;
         load_err <= 1'b0;
      end else begin
         count    <= next_count;
         carry    <= carry_next;
         load_err <= load_err_next;
      end
   end

`ifdef JK_COUNTER_GRAY_OUT_EN
   // Gray copy is taken from next_count so it lands on the same edge as count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gray <= '0;
      end else begin
         gray <= next_count ^ (next_count >> 1);
      end
   end
`endif

endmodule

// File: tb/tb_jk_sync_counter.sv
// Testbench for jk_sync_counter (WIDTH=4, MODULUS=10): expected results are
// queued when stimulus is driven and compared after the clock edge.
module tb_jk_sync_counter;

   localparam int WIDTH   = 4;
   localparam int MODULUS = 10;

   logic             clk;
   logic             rst;
   logic             en;
   logic             up;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             carry;
   logic             load_err;
`ifdef JK_COUNTER_GRAY_OUT_EN
   logic [WIDTH-1:0] gray;
`endif

   jk_sync_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .carry    (carry),
      .load_err (load_err)
`ifdef JK_COUNTER_GRAY_OUT_EN
      ,
      .gray     (gray)
`endif
   );

   typedef struct {
      int cnt;
      int cy;
      int le;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_cnt  = 0;
   int   m_cy   = 0;
   int   m_le   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_model();
      exp_t e;
      e.cnt = m_cnt;
      e.cy  = m_cy;
      e.le  = m_le;
      sb.push_back(e);
   endtask

   // Pop one expected entry and compare it against the DUT outputs.
   task automatic pop_compare(input string tag);
      exp_t e;
      int   exp_tc;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
         return;
      end
      e      = sb.pop_front();
      exp_tc = (up && e.cnt == MODULUS - 1) || (!up && e.cnt == 0) ? 1 : 0;
      chk({tag, "_count"},    int'(count),    e.cnt);
      chk({tag, "_carry"},    int'(carry),    e.cy);
      chk({tag, "_load_err"}, int'(load_err), e.le);
      chk({tag, "_tc"},       int'(tc),       exp_tc);
`ifdef JK_COUNTER_GRAY_OUT_EN
      chk({tag, "_gray"},     int'(gray),     e.cnt ^ (e.cnt >> 1));
`endif
   endtask

   // Reference behaviour written arithmetically, independent of JK bit logic.
   task automatic model_edge();
      m_cy = 0;
      m_le = 0;
      if (clr) begin
         m_cnt = 0;
      end else if (load) begin
         if (int'(load_val) < MODULUS) begin
            m_cnt = int'(load_val);
         end else begin
            m_cnt = 0;
            m_le  = 1;
         end
      end else if (en) begin
         if (up) begin
            if (m_cnt == MODULUS - 1) begin
               m_cnt = 0;
               m_cy  = 1;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end else begin
            if (m_cnt == 0) begin
               m_cnt = MODULUS - 1;
               m_cy  = 1;
            end else begin
               m_cnt = m_cnt - 1;
            end
         end
      end
   endtask

   task automatic step(input string tag, input logic s_en, input logic s_up,
                       input logic s_clr, input logic s_load,
                       input logic [WIDTH-1:0] s_lv);
      @(negedge clk);
      en       = s_en;
      up       = s_up;
      clr      = s_clr;
      load     = s_load;
      load_val = s_lv;
      model_edge();
      push_model();
      @(posedge clk);
      #1;
      pop_compare(tag);
   endtask

   initial begin
      rst      = 1'b0;
      en       = 1'b0;
      up       = 1'b1;
      clr      = 1'b0;
      load     = 1'b0;
      load_val = '0;

      // Reset state
      #3;
      push_model();
      pop_compare("reset");
      @(negedge clk);
      rst = 1'b1;

      // Count up 12 edges from 0: 1..9,0,1,2
      for (int i = 0; i < 12; i++) step("up_cnt", 1'b1, 1'b1, 1'b0, 1'b0, '0);

      // Load 7, hold, then async reset between edges
      step("load7", 1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
      step("hold7", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      #2;
      rst   = 1'b0;
      m_cnt = 0;
      m_cy  = 0;
      m_le  = 0;
      #1;
      push_model();
      pop_compare("async_rst");
      @(negedge clk);
      rst = 1'b1;

      // Count down from 0: 9,8,7
      for (int i = 0; i < 3; i++) step("down_cnt", 1'b1, 1'b0, 1'b0, 1'b0, '0);
      step("tc_down_ld0", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

      // Legal then illegal load, then idle to see load_err drop
      step("load6",  1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
      step("load12", 1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
      step("idle",   1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      step("load15", 1'b1, 1'b1, 1'b0, 1'b1, 4'd15);
      step("load9",  1'b1, 1'b0, 1'b0, 1'b1, 4'd9);

      // clr beats load and en
      step("load4",  1'b0, 1'b1, 1'b0, 1'b1, 4'd4);
      step("clr_pri", 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);

      // Direction flip at 9: next is 8, no wrap
      step("load8",  1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
      step("up_to9", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      step("flip_dn", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

      // Down wrap back-to-back with up wrap
      step("load0",  1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      step("dn_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      step("up_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

      // Random mixed traffic
      for (int i = 0; i < 200; i++) begin
         step("rand",
              logic'($urandom_range(0, 3) != 0),
              logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 15) == 0),
              logic'($urandom_range(0, 7) == 0),
              WIDTH'($urandom_range(0, 15)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
